// File: rtl/traffic_pkg.sv
// Lamp codes, fault codes and head indices shared by the traffic controller and its monitor.
package traffic_pkg;

    localparam logic [1:0] GREEN      = 2'b00;
    localparam logic [1:0] YELLOW     = 2'b01;
    localparam logic [1:0] RED        = 2'b10;
    localparam logic [1:0] RED_YELLOW = 2'b11;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_CONFLICT     = 3'd1;
    localparam logic [2:0] FC_ILLEGAL_SEQ  = 3'd2;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd3;
    localparam logic [2:0] FC_STUCK        = 3'd4;

    localparam logic [1:0] HEAD_HW1   = 2'd0;
    localparam logic [1:0] HEAD_HW2   = 2'd1;
    localparam logic [1:0] HEAD_FARM1 = 2'd2;
    localparam logic [1:0] HEAD_FARM2 = 2'd3;

    typedef struct packed {
        logic       vld;
        logic [2:0] code;
        logic [1:0] src;
    } fault_t;

    // Only the four forward steps of the lamp cycle are legal changes.
    function automatic logic legal_step(input logic [1:0] from, input logic [1:0] to);
        return ((from == RED)        && (to == RED_YELLOW)) ||
               ((from == RED_YELLOW) && (to == GREEN))      ||
               ((from == GREEN)      && (to == YELLOW))     ||
               ((from == YELLOW)     && (to == RED));
    endfunction

    function automatic logic [1:0] lowest_head(input logic [3:0] hit);
        if (hit[0])      return HEAD_HW1;
        else if (hit[1]) return HEAD_HW2;
        else if (hit[2]) return HEAD_FARM1;
        else             return HEAD_FARM2;
    endfunction

endpackage

// File: rtl/head_checker.sv
// Per-head lamp history: previous value, dwell counter, sequence and yellow-length checks.
// Latency: flags are combinational on the current sample; history updates at the Go edge.
// Backpressure: none; a passive tap that only advances when go is high.
module head_checker
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       go,
    input  logic [1:0] lamp,
    output logic       changed,
    output logic       illegal_seq,
    output logic       short_yellow,
    output logic       is_open
);

    localparam logic [7:0] MIN_Y = 8'(MIN_YELLOW);

    logic [1:0] prev;
    logic [7:0] dwell;

    assign changed      = go && (lamp != prev);
    assign illegal_seq  = changed && !legal_step(prev, lamp);
    assign short_yellow = changed && (prev == YELLOW) && (dwell < MIN_Y);
    assign is_open      = (lamp == GREEN) || (lamp == YELLOW);

    // Dwell counts samples showing the current value, including the sample it first appeared.
    always_ff @(posedge clk) begin
        if (Rst) begin
            prev  <= RED;
            dwell <= 8'd0;
        end else if (go) begin
            prev <= lamp;
            if (changed)
                dwell <= 8'd1;
            else if (dwell != 8'hFF)
                dwell <= dwell + 8'd1;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor on the four signal-head buses; latches the first fault and requests flash-red.
// Latency: a fault condition on the inputs in cycle k shows on fault/flash_red from cycle k+1.
// Backpressure: none; observes the controller outputs only and never stalls or drives the heads.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int MIN_YELLOW  = 2,
    parameter int STUCK_LIMIT = 64,
    parameter int STRICT_SEQ  = 1
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       Go,
    input  logic [1:0] highway_signal1,
    input  logic [1:0] highway_signal2,
    input  logic [1:0] farm_signal1,
    input  logic [1:0] farm_signal2,
    input  logic       clr_fault,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_src,
    output logic       flash_red,
    output logic [7:0] phase_count
);

    localparam logic [7:0] STUCK_LAST = 8'(STUCK_LIMIT - 1);
    localparam logic       SEQ_EN     = (STRICT_SEQ != 0);

    logic [1:0] lamp [4];
    logic [3:0] changed;
    logic [3:0] illegal;
    logic [3:0] short_y;
    logic [3:0] open;

    logic       seeded;
    logic [7:0] stuck_cnt;
    logic       checks_en;
    logic       conflict;
    logic       stuck_hit;
    logic [3:0] illegal_hit;
    logic [3:0] short_hit;
    fault_t     cand;

    assign lamp[HEAD_HW1]   = highway_signal1;
    assign lamp[HEAD_HW2]   = highway_signal2;
    assign lamp[HEAD_FARM1] = farm_signal1;
    assign lamp[HEAD_FARM2] = farm_signal2;

    for (genvar h = 0; h < 4; h++) begin : g_head
        head_checker #(.MIN_YELLOW(MIN_YELLOW)) u_head (
            .clk          (clk),
            .Rst          (Rst),
            .go           (Go),
            .lamp         (lamp[h]),
            .changed      (changed[h]),
            .illegal_seq  (illegal[h]),
            .short_yellow (short_y[h]),
            .is_open      (open[h])
        );
    end

    // Sequence-based checks are suppressed on the seeding sample, whose history is stale.
    assign checks_en   = Go && seeded;
    assign conflict    = (open[HEAD_HW1] || open[HEAD_HW2]) && (open[HEAD_FARM1] || open[HEAD_FARM2]);
    assign illegal_hit = (checks_en && SEQ_EN) ? illegal : 4'b0000;
    assign short_hit   = checks_en ? short_y : 4'b0000;
    assign stuck_hit   = checks_en && (changed == 4'b0000) && (stuck_cnt >= STUCK_LAST);

    always_comb begin
        cand = '{vld: 1'b0, code: FC_NONE, src: HEAD_HW1};
        if (conflict)
            cand = '{vld: 1'b1, code: FC_CONFLICT,
                     src: open[HEAD_HW1] ? HEAD_HW1 : HEAD_HW2};
        else if (illegal_hit != 4'b0000)
            cand = '{vld: 1'b1, code: FC_ILLEGAL_SEQ, src: lowest_head(illegal_hit)};
        else if (short_hit != 4'b0000)
            cand = '{vld: 1'b1, code: FC_SHORT_YELLOW, src: lowest_head(short_hit)};
        else if (stuck_hit)
            cand = '{vld: 1'b1, code: FC_STUCK, src: HEAD_HW1};
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            seeded    <= 1'b0;
            stuck_cnt <= 8'd0;
        end else if (clr_fault) begin
            seeded    <= 1'b0;
            stuck_cnt <= 8'd0;
        end else if (Go) begin
            seeded <= 1'b1;
            if (!seeded || (changed != 4'b0000))
                stuck_cnt <= 8'd0;
            else if (stuck_cnt != 8'hFF)
                stuck_cnt <= stuck_cnt + 8'd1;
        end
    end

    // A clear in the same cycle as a live condition re-latches the new fault.
    always_ff @(posedge clk) begin
        if (Rst) begin
            fault      <= 1'b0;
            fault_code <= FC_NONE;
            fault_src  <= HEAD_HW1;
        end else if (!fault || clr_fault) begin
            fault      <= cand.vld;
            fault_code <= cand.code;
            fault_src  <= cand.src;
        end
    end

    assign flash_red = fault;

    always_ff @(posedge clk) begin
        if (Rst)
            phase_count <= 8'd0;
        else if (checks_en && changed[HEAD_HW1] && (highway_signal1 == GREEN) && (phase_count != 8'hFF))
            phase_count <= phase_count + 8'd1;
    end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed table of lamp patterns against hand-computed fault outputs, plus stuck-counter sequences.
module tb_traffic_conflict_monitor;

    localparam logic [1:0] G = 2'b00, Y = 2'b01, R = 2'b10, RY = 2'b11;

    logic       clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Go = 1'b0;
    logic [1:0] hw1 = R, hw2 = R, f1 = R, f2 = R;
    logic       clr_fault = 1'b0;

    logic       fault, flash_red;
    logic [2:0] fault_code;
    logic [1:0] fault_src;
    logic [7:0] phase_count;

    logic       ns_fault, ns_flash_red;
    logic [2:0] ns_fault_code;
    logic [1:0] ns_fault_src;
    logic [7:0] ns_phase_count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(.MIN_YELLOW(2), .STUCK_LIMIT(64), .STRICT_SEQ(1)) dut (
        .clk (clk), .Rst (Rst), .Go (Go),
        .highway_signal1 (hw1), .highway_signal2 (hw2),
        .farm_signal1 (f1), .farm_signal2 (f2),
        .clr_fault (clr_fault),
        .fault (fault), .fault_code (fault_code), .fault_src (fault_src),
        .flash_red (flash_red), .phase_count (phase_count)
    );

    traffic_conflict_monitor #(.MIN_YELLOW(2), .STUCK_LIMIT(64), .STRICT_SEQ(0)) dut_ns (
        .clk (clk), .Rst (Rst), .Go (Go),
        .highway_signal1 (hw1), .highway_signal2 (hw2),
        .farm_signal1 (f1), .farm_signal2 (f2),
        .clr_fault (clr_fault),
        .fault (ns_fault), .fault_code (ns_fault_code), .fault_src (ns_fault_src),
        .flash_red (ns_flash_red), .phase_count (ns_phase_count)
    );

    typedef struct {
        logic       rst, go, clr;
        logic [1:0] hw1, hw2, f1, f2;
        logic       e_fault;
        logic [2:0] e_code;
        logic [1:0] e_src;
        logic [7:0] e_phase;
        logic       e_ns_fault;
        logic [2:0] e_ns_code;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, go, clr, input logic [1:0] a, b, c, d,
                                input logic ef, input logic [2:0] ec, input logic [1:0] es,
                                input logic [7:0] ep, input logic nf, input logic [2:0] nc);
        vec_t v;
        v.rst = rst; v.go = go; v.clr = clr;
        v.hw1 = a; v.hw2 = b; v.f1 = c; v.f2 = d;
        v.e_fault = ef; v.e_code = ec; v.e_src = es; v.e_phase = ep;
        v.e_ns_fault = nf; v.e_ns_code = nc;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0d: got %0d, want %0d", nm, idx, act, exp);
        end
    endtask

    // Inputs change #1 after the edge; outputs are sampled #1 after the next edge.
    task automatic tick(input logic rst, go, clr, input logic [1:0] a, b, c, d);
        Rst = rst; Go = go; clr_fault = clr;
        hw1 = a; hw2 = b; f1 = c; f2 = d;
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    task automatic chk_fault(input string nm, input int idx, input logic ef,
                             input logic [2:0] ec, input logic [1:0] es);
        chk({nm, ".fault"}, idx, 8'(fault), 8'(ef));
        chk({nm, ".flash_red"}, idx, 8'(flash_red), 8'(ef));
        chk({nm, ".code"}, idx, 8'(fault_code), 8'(ec));
        chk({nm, ".src"}, idx, 8'(fault_src), 8'(es));
    endtask

    initial begin
        //                rst go  clr hw1 hw2 f1  f2  flt code src phase nsf nsc
        tbl.push_back(mk(1, 0, 0, R,  R,  R,  R,  0, 0, 0, 0, 0, 0)); // reset
        tbl.push_back(mk(0, 1, 0, R,  R,  R,  R,  0, 0, 0, 0, 0, 0)); // seed
        tbl.push_back(mk(0, 1, 0, RY, RY, R,  R,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, G,  G,  R,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, Y,  Y,  R,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, Y,  Y,  R,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, Y,  Y,  R,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, R,  R,  R,  R,  0, 0, 0, 1, 0, 0)); // yellow dwell 3: ok
        tbl.push_back(mk(0, 0, 0, G,  R,  R,  Y,  1, 1, 0, 1, 1, 1)); // conflict with Go=0
        tbl.push_back(mk(0, 0, 1, R,  R,  R,  R,  0, 0, 0, 1, 0, 0)); // clear
        tbl.push_back(mk(0, 1, 0, R,  R,  R,  R,  0, 0, 0, 1, 0, 0)); // re-seed
        tbl.push_back(mk(0, 1, 0, R,  G,  R,  R,  1, 2, 1, 1, 0, 0)); // hw2 RED->GREEN
        tbl.push_back(mk(0, 0, 1, R,  R,  R,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, R,  R,  R,  R,  0, 0, 0, 1, 0, 0)); // seed
        tbl.push_back(mk(0, 1, 0, R,  R,  RY, R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, R,  R,  G,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, R,  R,  Y,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, R,  R,  R,  R,  1, 3, 2, 1, 1, 3)); // yellow for 1 sample
        tbl.push_back(mk(0, 0, 0, G,  R,  G,  R,  1, 3, 2, 1, 1, 3)); // later conflict ignored
        tbl.push_back(mk(0, 0, 1, R,  R,  R,  R,  0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, R,  R,  R,  R,  0, 0, 0, 1, 0, 0)); // seed
        tbl.push_back(mk(0, 1, 0, G,  R,  G,  Y,  1, 1, 0, 2, 1, 1)); // conflict beats illegal
        tbl.push_back(mk(0, 0, 1, G,  R,  G,  R,  1, 1, 0, 2, 1, 1)); // clear vs live conflict
        tbl.push_back(mk(1, 0, 1, G,  R,  G,  R,  0, 0, 0, 0, 0, 0)); // Rst wins

        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].rst, tbl[i].go, tbl[i].clr, tbl[i].hw1, tbl[i].hw2, tbl[i].f1, tbl[i].f2);
            chk_fault("tbl", i, tbl[i].e_fault, tbl[i].e_code, tbl[i].e_src);
            chk("tbl.phase", i, phase_count, tbl[i].e_phase);
            chk("tbl.ns_fault", i, 8'(ns_fault), 8'(tbl[i].e_ns_fault));
            chk("tbl.ns_code", i, 8'(ns_fault_code), 8'(tbl[i].e_ns_code));
        end

        // Stuck: seed, then 63 quiet samples are tolerated and the 64th raises STUCK.
        tick(0, 1, 0, R, R, R, R);
        chk_fault("stuck.seed", 0, 0, 0, 0);
        for (int i = 1; i <= 63; i++) begin
            tick(0, 1, 0, R, R, R, R);
            chk("stuck.quiet", i, 8'(fault), 8'd0);
        end
        tick(0, 1, 0, R, R, R, R);
        chk_fault("stuck.64", 64, 1, 4, 0);

        tick(0, 0, 1, R, R, R, R);
        chk_fault("stuck.clr", 0, 0, 0, 0);

        // The counter must hold across a long Go=0 stretch, then trip on the next sample.
        tick(0, 1, 0, R, R, R, R);
        for (int i = 1; i <= 63; i++)
            tick(0, 1, 0, R, R, R, R);
        chk("hold.63", 63, 8'(fault), 8'd0);
        for (int i = 0; i < 200; i++) begin
            tick(0, 0, 0, R, R, R, R);
            chk("hold.go0", i, 8'(fault), 8'd0);
        end
        tick(0, 1, 0, R, R, R, R);
        chk_fault("hold.64", 64, 1, 4, 0);

        // A change on any head restarts the quiet count.
        tick(0, 0, 1, R, R, R, R);
        tick(0, 1, 0, R, R, R, R);
        for (int i = 1; i <= 40; i++)
            tick(0, 1, 0, R, R, R, R);
        tick(0, 1, 0, R, R, RY, R);
        for (int i = 1; i <= 63; i++)
            tick(0, 1, 0, R, R, RY, R);
        chk_fault("restart.63", 63, 0, 0, 0);
        tick(0, 1, 0, R, R, RY, R);
        chk_fault("restart.64", 64, 1, 4, 0);

        tick(1, 0, 0, R, R, R, R);
        chk_fault("final.rst", 0, 0, 0, 0);
        chk("final.phase", 0, phase_count, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
